// File: rtl/mini_i_fetch_pkg.sv
// Shared types and constants for the mini_i_fetch instruction fetch stage.
package mini_i_fetch_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 32;
    localparam int FIFO_DEPTH  = 4;
    localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0;

    // PC step in bytes for one instruction.
    localparam int INST_BYTES  = DATA_WIDTH / 8;
    localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

    // Force a fetch address onto an instruction boundary.
    function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] pc);
        return pc & ~ADDR_WIDTH'(INST_BYTES - 1);
    endfunction

endpackage

// File: rtl/mini_i_fetch_fifo.sv
// Small synchronous FIFO used both as the decode instruction buffer and
// as the in-flight request PC queue. Flush wins over push and pop.
module mini_i_fetch_fifo
    import mini_i_fetch_pkg::*;
#(
    parameter type entry_t     = fetch_entry_t,
    parameter int  depth       = FIFO_DEPTH,
    parameter int  count_width = $clog2(depth + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head,
    output logic [count_width-1:0] count
);

    localparam int ptr_width = $clog2(depth);

    entry_t               mem [depth];
    logic [ptr_width-1:0] wr_ptr;
    logic [ptr_width-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != count_width'(depth)) || do_pop);
    assign head    = mem[rd_ptr];

    // Storage write port.
    // NOTE: the data array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; reset and flush both empty the FIFO.
    // NOTE: reset is sampled only on the clock edge, so it sits inside the clocked block, not in the sensitivity list.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ptr_width'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ptr_width'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + count_width'(1);
            end else if (do_pop && !do_push) begin
                count <= count - count_width'(1);
            end
        end
    end

endmodule

// File: rtl/mini_i_fetch.sv
// Instruction fetch stage: issues sequential PCs to the cache under a credit
// limit, pairs in-order responses with their PCs and buffers them for decode.
// A redirect reloads the PC, flushes buffered work and drops late responses.
module mini_i_fetch
    import mini_i_fetch_pkg::*;
#(
    parameter int                    fifo_depth   = FIFO_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] reset_vector = RESET_VECTOR
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    output logic [ADDR_WIDTH-1:0] ir_addr,
    input  logic                  ir_data_valid,
    output logic                  ir_data_ready,
    input  logic [DATA_WIDTH-1:0] ir_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc
);

    localparam int cw        = $clog2(fifo_depth + 1);
    localparam int sum_width = cw + 1;

    logic [ADDR_WIDTH-1:0] pc;
    logic [cw-1:0]         outstanding;
    logic [cw-1:0]         discard;
    logic [cw-1:0]         fifo_count;
    logic [cw-1:0]         inflight_count;
    logic [sum_width-1:0]  in_use;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    fetch_entry_t          fifo_head;
    fetch_entry_t          fifo_push_data;
    logic                  issue;
    logic                  resp;
    logic                  drop;
    logic                  push_inst;
    logic                  pop_inflight;

    // Every buffered instruction and every in-flight request holds one credit.
    assign in_use        = sum_width'(fifo_count) + sum_width'(outstanding);
    assign ir_addr_valid = reset && !redirect_valid && (in_use < sum_width'(fifo_depth));
    assign ir_addr       = pc;
    assign ir_data_ready = 1'b1;

    assign issue = ir_addr_valid && ir_addr_ready;
    // Responses with nothing outstanding belong to a cache that was reset with us.
    assign resp  = reset && ir_data_valid && (outstanding != '0);
    assign drop  = redirect_valid || (discard != '0);

    assign push_inst      = resp && !drop;
    // Discarded responses were removed from the PC queue at redirect time.
    assign pop_inflight   = resp && (discard == '0) && (inflight_count != '0);
    assign fifo_push_data = '{pc: inflight_pc, inst: ir_data};

    assign inst_valid = (fifo_count != '0);
    assign inst_data  = fifo_head.inst;
    assign inst_pc    = fifo_head.pc;

    // PC, in-flight count and pending-discard count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc          <= reset_vector;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            // Nothing issues this cycle; everything still in flight is stale.
            pc          <= align_pc(redirect_pc);
            outstanding <= outstanding - cw'(resp);
            discard     <= outstanding - cw'(resp);
        end else begin
            if (issue) begin
                pc <= pc + ADDR_WIDTH'(INST_BYTES);
            end
            outstanding <= outstanding + cw'(issue) - cw'(resp);
            if (resp && (discard != '0)) begin
                discard <= discard - cw'(1);
            end
        end
    end

    mini_i_fetch_fifo #(
        .entry_t     (logic [ADDR_WIDTH-1:0]),
        .depth       (fifo_depth),
        .count_width (cw)
    ) u_inflight_q (
        .clock     (clock),
        .reset     (reset),
        .push      (issue),
        .push_data (pc),
        .pop       (pop_inflight),
        .flush     (redirect_valid),
        .head      (inflight_pc),
        .count     (inflight_count)
    );

    mini_i_fetch_fifo #(
        .entry_t     (fetch_entry_t),
        .depth       (fifo_depth),
        .count_width (cw)
    ) u_inst_q (
        .clock     (clock),
        .reset     (reset),
        .push      (push_inst),
        .push_data (fifo_push_data),
        .pop       (inst_ready),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mini_i_fetch.sv
// Self-checking bench for mini_i_fetch: directed table, corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_mini_i_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ir_addr_valid;
    logic        ir_addr_ready = 1'b0;
    logic [31:0] ir_addr;
    logic        ir_data_valid = 1'b0;
    logic        ir_data_ready;
    logic [31:0] ir_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    // Second instance for the PC wrap-around check.
    logic        w_reset = 1'b0;
    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc = '0;
    logic        w_ir_addr_valid;
    logic        w_ir_addr_ready = 1'b0;
    logic [31:0] w_ir_addr;
    logic        w_ir_data_valid = 1'b0;
    logic        w_ir_data_ready;
    logic [31:0] w_ir_data = '0;
    logic        w_inst_valid;
    logic        w_inst_ready = 1'b0;
    logic [31:0] w_inst_data;
    logic [31:0] w_inst_pc;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    mini_i_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_addr_valid  (ir_addr_valid),
        .ir_addr_ready  (ir_addr_ready),
        .ir_addr        (ir_addr),
        .ir_data_valid  (ir_data_valid),
        .ir_data_ready  (ir_data_ready),
        .ir_data        (ir_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    mini_i_fetch #(.reset_vector(32'hFFFF_FFFC)) dut_wrap (
        .clock          (clock),
        .reset          (w_reset),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .ir_addr_valid  (w_ir_addr_valid),
        .ir_addr_ready  (w_ir_addr_ready),
        .ir_addr        (w_ir_addr),
        .ir_data_valid  (w_ir_data_valid),
        .ir_data_ready  (w_ir_data_ready),
        .ir_data        (w_ir_data),
        .inst_valid     (w_inst_valid),
        .inst_ready     (w_inst_ready),
        .inst_data      (w_inst_data),
        .inst_pc        (w_inst_pc)
    );

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; bit live; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;

    req_t        inflight[$];   // every request the cache still owes, oldest first
    inst_t       inst_q[$];     // instructions waiting for decode
    logic [31:0] m_pc = 32'h0;
    bit          cache_on = 1'b0;
    bit          cache_rand = 1'b0;

    function automatic bit model_av();
        return reset && !redirect_valid && ((inst_q.size() + inflight.size()) < 4);
    endfunction

    task automatic model_update();
        bit    resp;
        bit    av;
        req_t  r;
        if (!reset) begin
            m_pc = 32'h0;
            inflight.delete();
            inst_q.delete();
        end else begin
            av   = model_av();
            resp = ir_data_valid && (inflight.size() > 0);
            if (redirect_valid) begin
                if (resp) void'(inflight.pop_front());
                inst_q.delete();
                foreach (inflight[i]) inflight[i].live = 1'b0;
                m_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (inst_q.size() > 0 && inst_ready) void'(inst_q.pop_front());
                if (resp) begin
                    r = inflight.pop_front();
                    if (r.live) inst_q.push_back('{pc: r.pc, data: ir_data});
                end
                if (av && ir_addr_ready) begin
                    inflight.push_back('{pc: m_pc, live: 1'b1});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("ir_addr_valid", {31'b0, ir_addr_valid}, {31'b0, model_av()});
        check("ir_addr", ir_addr, m_pc);
        check("ir_data_ready", {31'b0, ir_data_ready}, 32'd1);
        check("inst_valid", {31'b0, inst_valid}, {31'b0, inst_q.size() != 0});
        if (inst_q.size() != 0) begin
            check("inst_pc", inst_pc, inst_q[0].pc);
            check("inst_data", inst_data, inst_q[0].data);
        end
    endtask

    // Cache stand-in: answers owed requests in order, at least one cycle after acceptance.
    task automatic drive_cache();
        if (cache_on && inflight.size() > 0 && (!cache_rand || $urandom_range(1, 0) == 1)) begin
            ir_data_valid = 1'b1;
            ir_data       = cache_rand ? $urandom : inflight[0].pc + 32'h100;
        end else begin
            ir_data_valid = 1'b0;
            ir_data       = '0;
        end
    endtask

    task automatic begin_cycle();
        drive_cache();
        @(negedge clock);
    endtask

    task automatic end_cycle();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic run_cycle();
        begin_cycle();
        compare_model();
        end_cycle();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0; redirect_valid = 1'b0; ir_addr_ready = 1'b0; inst_ready = 1'b0;
        cache_on = 1'b0;
        for (int i = 0; i < cycles; i++) run_cycle();
        reset = 1'b1;
    endtask

    // Bounded wait for the first instruction to reach decode.
    task automatic wait_first_inst(input string name, input logic [31:0] exp_pc);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            begin_cycle();
            if (inst_valid) begin
                seen = 1'b1;
                check(name, inst_pc, exp_pc);
                check({name, "_data"}, inst_data, exp_pc + 32'h100);
            end
            compare_model();
            end_cycle();
        end
        if (!seen) check({name, "_timeout"}, {31'b0, seen}, 32'd1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst, redir;
        logic [31:0] rpc;
        logic        ar, dv;
        logic [31:0] dd;
        logic        ir;
        logic        av;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc, idata;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic ar, input logic dv, input logic [31:0] dd,
                                input logic ir, input logic av, input logic [31:0] addr,
                                input logic iv, input logic [31:0] ipc, input logic [31:0] idata);
        vec_t v;
        v.rst = rst; v.redir = 1'b0; v.rpc = '0; v.ar = ar; v.dv = dv; v.dd = dd; v.ir = ir;
        v.av = av; v.addr = addr; v.iv = iv; v.ipc = ipc; v.idata = idata;
        return v;
    endfunction

    vec_t        vecs[10];
    logic [31:0] issued[$];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset hold, then one-cycle-latency sequential stream with data = addr + 0x100.
        vecs[0] = mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0, 32'h0);
        vecs[1] = mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0, 32'h0);
        vecs[2] = mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0, 32'h0);
        vecs[3] = mk(1, 1, 0, 32'h0,   1, 1, 32'h0,  0, 32'h0, 32'h0);
        vecs[4] = mk(1, 1, 1, 32'h100, 1, 1, 32'h4,  0, 32'h0, 32'h0);
        vecs[5] = mk(1, 1, 1, 32'h104, 1, 1, 32'h8,  1, 32'h0, 32'h100);
        vecs[6] = mk(1, 1, 1, 32'h108, 1, 1, 32'hC,  1, 32'h4, 32'h104);
        vecs[7] = mk(1, 0, 1, 32'h10C, 1, 1, 32'h10, 1, 32'h8, 32'h108);
        vecs[8] = mk(1, 0, 0, 32'h0,   1, 1, 32'h10, 1, 32'hC, 32'h10C);
        vecs[9] = mk(1, 0, 0, 32'h0,   1, 1, 32'h10, 0, 32'h0, 32'h0);

        // Wrap-around from the top of the address space.
        w_reset = 1'b0; w_ir_addr_ready = 1'b1;
        @(negedge clock);
        check("wrap_reset_valid", {31'b0, w_ir_addr_valid}, 32'd0);
        check("wrap_reset_addr", w_ir_addr, 32'hFFFF_FFFC);
        @(posedge clock); #1;
        w_reset = 1'b1;
        @(negedge clock);
        check("wrap_first_valid", {31'b0, w_ir_addr_valid}, 32'd1);
        check("wrap_first_addr", w_ir_addr, 32'hFFFF_FFFC);
        @(posedge clock); #1;
        @(negedge clock);
        check("wrap_second_valid", {31'b0, w_ir_addr_valid}, 32'd1);
        check("wrap_second_addr", w_ir_addr, 32'h0000_0000);
        @(posedge clock); #1;
        w_ir_addr_ready = 1'b0;

        // Table-driven reset + sequential stream.
        foreach (vecs[i]) begin
            reset = vecs[i].rst; redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
            ir_addr_ready = vecs[i].ar; ir_data_valid = vecs[i].dv; ir_data = vecs[i].dd;
            inst_ready = vecs[i].ir;
            @(negedge clock);
            check($sformatf("tbl%0d_addr_valid", i), {31'b0, ir_addr_valid}, {31'b0, vecs[i].av});
            check($sformatf("tbl%0d_addr", i), ir_addr, vecs[i].addr);
            check($sformatf("tbl%0d_data_ready", i), {31'b0, ir_data_ready}, 32'd1);
            check($sformatf("tbl%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].iv});
            if (vecs[i].iv) begin
                check($sformatf("tbl%0d_inst_pc", i), inst_pc, vecs[i].ipc);
                check($sformatf("tbl%0d_inst_data", i), inst_data, vecs[i].idata);
            end
            end_cycle();
        end

        // Backpressure: four credits, then stall until decode pops one.
        do_reset(2);
        ir_addr_ready = 1'b1; inst_ready = 1'b0; cache_on = 1'b1; cache_rand = 1'b0;
        for (int i = 0; i < 8; i++) begin
            begin_cycle();
            if (ir_addr_valid && ir_addr_ready) issued.push_back(ir_addr);
            compare_model();
            end_cycle();
        end
        check("bp_issue_count", issued.size(), 32'd4);
        for (int i = 0; i < issued.size() && i < 4; i++)
            check($sformatf("bp_issue%0d", i), issued[i], 32'(i * 4));
        begin_cycle();
        check("bp_stalled", {31'b0, ir_addr_valid}, 32'd0);
        compare_model();
        end_cycle();
        inst_ready = 1'b1;
        run_cycle();
        inst_ready = 1'b0;
        begin_cycle();
        check("bp_resume_valid", {31'b0, ir_addr_valid}, 32'd1);
        check("bp_resume_addr", ir_addr, 32'h10);
        compare_model();
        end_cycle();

        // Redirect with two requests in flight: both late responses dropped.
        do_reset(2);
        ir_addr_ready = 1'b1; inst_ready = 1'b1; cache_on = 1'b0;
        run_cycle();
        run_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        begin_cycle();
        check("rd_valid_forced_low", {31'b0, ir_addr_valid}, 32'd0);
        compare_model();
        end_cycle();
        redirect_valid = 1'b0; cache_on = 1'b1;
        begin_cycle();
        check("rd_new_valid", {31'b0, ir_addr_valid}, 32'd1);
        check("rd_new_addr", ir_addr, 32'h200);
        compare_model();
        end_cycle();
        wait_first_inst("rd_first_inst_pc", 32'h200);

        // Redirect coincident with a response and a decode pop.
        do_reset(2);
        ir_addr_ready = 1'b1; inst_ready = 1'b0; cache_on = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h400; inst_ready = 1'b1;
        begin_cycle();
        check("co_resp_present", {31'b0, ir_data_valid}, 32'd1);
        check("co_valid_forced_low", {31'b0, ir_addr_valid}, 32'd0);
        compare_model();
        end_cycle();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        begin_cycle();
        check("co_fifo_empty", {31'b0, inst_valid}, 32'd0);
        check("co_new_addr", ir_addr, 32'h400);
        compare_model();
        end_cycle();
        inst_ready = 1'b1;
        wait_first_inst("co_first_inst_pc", 32'h400);

        // Randomized traffic against the model.
        cache_on = 1'b1; cache_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(299, 0) != 0);
            redirect_valid = ($urandom_range(15, 0) == 0);
            redirect_pc    = $urandom;
            ir_addr_ready  = ($urandom_range(3, 0) != 0);
            inst_ready     = (((i / 200) % 3) == 1) ? ($urandom_range(7, 0) == 0)
                                                    : ($urandom_range(1, 0) == 1);
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
